// File: rtl/ste_lmc1992.sv
// rtl/ste_lmc1992.sv - STE LMC1992 volume/mixer emulation: microwire decode, YM mix, attenuation
module ste_lmc1992 #(
  parameter int SAMPLE_DIV = 64
) (
  input  logic               clk32,
  input  logic               reset,
  input  logic               mw_stb,
  input  logic               mw_clk,
  input  logic               mw_data,
  input  logic               mw_done,
  input  logic [7:0]         dma_l,
  input  logic [7:0]         dma_r,
  input  logic [7:0]         ym_in,
  output logic signed [15:0] audio_l,
  output logic signed [15:0] audio_r,
  output logic               sample_valid,
  output logic [3:0]         bass,
  output logic [3:0]         treble
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);

  typedef enum logic [2:0] {IDLE, GAIN, MUL_L, MUL_R, OUT} state_t;

  state_t state_q, state_d;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  logic [10:0] shift_reg;
  logic [3:0]  bit_cnt;
  logic        done_d;
  logic        done_rise;
  logic        bit_take;
  logic [5:0]  cmd_data;

  logic [5:0] master;
  logic [4:0] vol_l;
  logic [4:0] vol_r;
  logic [1:0] mix;

  logic [7:0] hold_l, hold_r, hold_ym;
  logic [6:0] att_l, att_r;
  logic [6:0] q_l, q_r;
  logic [8:0] g_l, g_r;
  logic [1:0] mix_q;

  logic signed [7:0]  dl_s, dr_s, ym_s, y_s;
  logic signed [9:0]  s_l, s_r, mul_s;
  logic [8:0]         mul_g;
  logic [6:0]         mul_q;
  logic signed [17:0] mul_a, mul_b, prod;
  logic signed [15:0] mul_out;
  logic signed [15:0] res_l, res_r;

  // Fractional part of the 2 dB-per-step attenuation as a x/256 gain
  function automatic logic [8:0] gain_of(input logic [6:0] a);
    case (a % 7'd3)
      7'd0:    gain_of = 9'd256;
      7'd1:    gain_of = 9'd203;
      default: gain_of = 9'd161;
    endcase
  endfunction

  assign tick      = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign done_rise = mw_done & ~done_d;
  assign bit_take  = mw_stb & mw_clk;
  assign cmd_data  = shift_reg[5:0];

  // Free-running sample-rate divider
  always_ff @(posedge clk32) begin
    if (reset || tick) div_cnt <= '0;
    else               div_cnt <= div_cnt + DIV_W'(1);
  end

  // Microwire capture and command decode into the mixer/tone/volume registers
  always_ff @(posedge clk32) begin
    if (reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      done_d    <= 1'b0;
      master    <= 6'd40;
      vol_l     <= 5'd20;
      vol_r     <= 5'd20;
      mix       <= 2'b01;
      bass      <= 4'd6;
      treble    <= 4'd6;
    end else begin
      done_d <= mw_done;
      if (bit_take) shift_reg <= {shift_reg[9:0], mw_data};
      if (done_rise)                         bit_cnt <= '0;
      else if (bit_take && bit_cnt < 4'd12)  bit_cnt <= bit_cnt + 4'd1;
      if (done_rise && bit_cnt == 4'd11 && shift_reg[10:9] == 2'b10) begin
        case (shift_reg[8:6])
          3'b000: mix    <= cmd_data[1:0];
          3'b001: bass   <= (cmd_data[3:0] > 4'd12) ? 4'd12 : cmd_data[3:0];
          3'b010: treble <= (cmd_data[3:0] > 4'd12) ? 4'd12 : cmd_data[3:0];
          3'b011: master <= (cmd_data > 6'd40) ? 6'd40 : cmd_data;
          3'b100: vol_r  <= (cmd_data[4:0] > 5'd20) ? 5'd20 : cmd_data[4:0];
          3'b101: vol_l  <= (cmd_data[4:0] > 5'd20) ? 5'd20 : cmd_data[4:0];
          default: ;
        endcase
      end
    end
  end

  // Attenuation, mixed inputs and the shared multiplier for the current channel
  always_comb begin
    att_l = {1'b0, 6'd40 - master} + {2'b00, 5'd20 - vol_l};
    att_r = {1'b0, 6'd40 - master} + {2'b00, 5'd20 - vol_r};
    dl_s  = {~hold_l[7], hold_l[6:0]};
    dr_s  = {~hold_r[7], hold_r[6:0]};
    ym_s  = {~hold_ym[7], hold_ym[6:0]};
    case (mix_q)
      2'b01:   y_s = ym_s;
      2'b00:   y_s = ym_s >>> 2;
      default: y_s = '0;
    endcase
    s_l = $signed({{2{dl_s[7]}}, dl_s}) + $signed({{2{y_s[7]}}, y_s});
    s_r = $signed({{2{dr_s[7]}}, dr_s}) + $signed({{2{y_s[7]}}, y_s});
    mul_s = (state_q == MUL_R) ? s_r : s_l;
    mul_g = (state_q == MUL_R) ? g_r : g_l;
    mul_q = (state_q == MUL_R) ? q_r : q_l;
    mul_a = {{8{mul_s[9]}}, mul_s};
    mul_b = $signed({9'b0, mul_g});
    prod  = mul_a * mul_b;
    mul_out = (mul_q >= 7'd14) ? 16'sd0 : 16'(prod >>> (mul_q + 7'd2));
  end

  // Sample FSM state register
  always_ff @(posedge clk32) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Sample FSM next state: one cycle per step once a tick is seen
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = GAIN;
      GAIN:    state_d = MUL_L;
      MUL_L:   state_d = MUL_R;
      MUL_R:   state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sample datapath: input capture, gain latch, per-channel products, output write
  always_ff @(posedge clk32) begin
    if (reset) begin
      hold_l       <= 8'h80;
      hold_r       <= 8'h80;
      hold_ym      <= 8'h80;
      q_l          <= '0;
      q_r          <= '0;
      g_l          <= '0;
      g_r          <= '0;
      mix_q        <= 2'b01;
      res_l        <= '0;
      res_r        <= '0;
      audio_l      <= '0;
      audio_r      <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state_q)
        IDLE: if (tick) begin
          hold_l  <= dma_l;
          hold_r  <= dma_r;
          hold_ym <= ym_in;
        end
        GAIN: begin
          q_l   <= att_l / 7'd3;
          q_r   <= att_r / 7'd3;
          g_l   <= gain_of(att_l);
          g_r   <= gain_of(att_r);
          mix_q <= mix;
        end
        MUL_L: res_l <= mul_out;
        MUL_R: res_r <= mul_out;
        OUT: begin
          audio_l      <= res_l;
          audio_r      <= res_r;
          sample_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ste_lmc1992.sv
// tb/tb_ste_lmc1992.sv - directed self-checking bench for ste_lmc1992
module tb_ste_lmc1992;

  logic               clk32 = 1'b0;
  logic               reset;
  logic               mw_stb, mw_clk, mw_data, mw_done;
  logic [7:0]         dma_l, dma_r, ym_in;
  logic signed [15:0] audio_l, audio_r;
  logic               sample_valid;
  logic [3:0]         bass, treble;

  int checks = 0;
  int errors = 0;

  ste_lmc1992 #(.SAMPLE_DIV(64)) dut (
    .clk32(clk32), .reset(reset),
    .mw_stb(mw_stb), .mw_clk(mw_clk), .mw_data(mw_data), .mw_done(mw_done),
    .dma_l(dma_l), .dma_r(dma_r), .ym_in(ym_in),
    .audio_l(audio_l), .audio_r(audio_r), .sample_valid(sample_valid),
    .bass(bass), .treble(treble)
  );

  always #5 clk32 = ~clk32;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk32);
      if (sample_valid) seen = 1'b1;
    end
    check({tag, "_valid_seen"}, seen, 1);
  endtask

  task automatic settle(input string tag);
    wait_valid(tag);
    wait_valid(tag);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk32); mw_stb = 1'b1; mw_clk = 1'b1; mw_data = bits[i];
      @(negedge clk32); mw_stb = 1'b1; mw_clk = 1'b0; mw_data = ~bits[i];
      @(negedge clk32); mw_stb = 1'b0; mw_clk = 1'b0; mw_data = 1'b0;
    end
    @(negedge clk32); mw_done = 1'b1;
    @(negedge clk32);
    @(negedge clk32); mw_done = 1'b0;
    @(negedge clk32);
  endtask

  task automatic do_reset();
    @(negedge clk32);
    reset = 1'b1; mw_stb = 1'b0; mw_clk = 1'b0; mw_data = 1'b0; mw_done = 1'b0;
    repeat (3) @(negedge clk32);
    reset = 1'b0;
  endtask

  initial begin
    bit stray_valid;
    reset = 1'b1; mw_stb = 1'b0; mw_clk = 1'b0; mw_data = 1'b0; mw_done = 1'b0;
    dma_l = 8'hC0; dma_r = 8'hC0; ym_in = 8'h80;
    repeat (3) @(negedge clk32);
    check("rst_audio_l", audio_l, 0);
    check("rst_audio_r", audio_r, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_bass", bass, 6);
    check("rst_treble", treble, 6);
    reset = 1'b0;

    wait_valid("first");
    check("default_l", audio_l, 4096);
    check("default_r", audio_r, 4096);

    // capture happens at the tick edge, output 4 cycles later; later input changes are ignored
    repeat (59) @(negedge clk32);
    dma_l = 8'h00;
    @(negedge clk32);
    dma_l = 8'hC0;
    repeat (3) @(negedge clk32);
    check("valid_before_t4", sample_valid, 0);
    @(negedge clk32);
    check("valid_at_t4", sample_valid, 1);
    check("neg_full_l", audio_l, -8192);
    check("neg_full_r", audio_r, 4096);
    @(negedge clk32);
    check("valid_end_t5", sample_valid, 0);
    check("hold_l", audio_l, -8192);
    settle("restore");
    check("restore_l", audio_l, 4096);

    send_bits(11'b10_011_100010, 11);
    settle("master34");
    check("master34_l", audio_l, 1024);
    check("master34_r", audio_r, 1024);

    send_bits(11'b10_011_101000, 11);
    send_bits(11'b10_101_010011, 11);
    settle("left19");
    check("left19_l", audio_l, 3248);
    check("left19_r", audio_r, 4096);

    do_reset();
    ym_in = 8'hFF;
    settle("mix01");
    check("mix01_l", audio_l, 12224);
    check("mix01_r", audio_r, 12224);
    send_bits(11'b10_000_000010, 11);
    settle("mix10");
    check("mix10_l", audio_l, 4096);
    send_bits(11'b10_000_000000, 11);
    settle("mix00");
    check("mix00_l", audio_l, 6080);
    check("mix00_r", audio_r, 6080);
    ym_in = 8'h80;

    do_reset();
    send_bits(11'b10_001_001111, 11);
    check("bass_clamp", bass, 12);
    send_bits(11'b10_010_000011, 11);
    check("treble_set", treble, 3);

    send_bits(16'b10_0111_0001, 10);
    settle("short10");
    check("short10_l", audio_l, 4096);
    send_bits(12'b1_10_011_100010, 12);
    settle("long12");
    check("long12_l", audio_l, 4096);
    send_bits(11'b01_011_100010, 11);
    settle("addr01");
    check("addr01_l", audio_l, 4096);
    send_bits(11'b10_110_100010, 11);
    settle("func110");
    check("func110_l", audio_l, 4096);
    check("func110_bass", bass, 12);
    check("func110_treble", treble, 3);

    send_bits(11'b10_011_100010, 11);
    settle("master34b");
    check("master34b_l", audio_l, 1024);
    send_bits(11'b10_011_111111, 11);
    settle("master63");
    check("master63_l", audio_l, 4096);
    check("master63_r", audio_r, 4096);

    send_bits(11'b10_011_000000, 11);
    send_bits(11'b10_101_000000, 11);
    settle("limit");
    check("limit_l", audio_l, 0);
    check("limit_r", audio_r, 0);

    send_bits(11'b10_011_100010, 11);
    settle("mixed_att");
    check("att26_l", audio_l, 10);
    check("att6_r", audio_r, 1024);

    // reset while the FSM sits in MUL_R (tick edge is 60 cycles after this valid)
    repeat (62) @(negedge clk32);
    reset = 1'b1;
    repeat (2) @(negedge clk32);
    check("mid_rst_l", audio_l, 0);
    check("mid_rst_r", audio_r, 0);
    check("mid_rst_valid", sample_valid, 0);
    reset = 1'b0;
    stray_valid = 1'b0;
    repeat (10) begin
      @(negedge clk32);
      if (sample_valid) stray_valid = 1'b1;
    end
    check("mid_rst_no_valid", stray_valid, 0);
    settle("after_rst");
    check("after_rst_l", audio_l, 4096);
    check("after_rst_r", audio_r, 4096);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
